// File: rtl/ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// ram_arb_pkg
// Shared sizing and FSM encoding for the two-requester RAM arbiter.
//   ADDR_W : RAM address width (32K words)
//   DATA_W : RAM data width
//   NREQ   : number of requesters (bit0 = CPU, bit1 = DMA/loader)
// -----------------------------------------------------------------------------
package ram_arb_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int NREQ   = 2;

    typedef enum logic {
        ST_ARB    = 1'b0,   // free arbitration every cycle
        ST_LOCKED = 1'b1    // burst owner holds the RAM
    } arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// -----------------------------------------------------------------------------
// ram_arb_pick
// Combinational winner selection between the two requesters.
// Configuration macro: RAM_ARB_RR_EN
//   defined   -> round-robin: the requester granted last loses a tie
//   undefined -> fixed priority: requester 0 wins a tie
// A yield request overrides both schemes for one tie, so a requester that
// just lost a full burst gets the RAM next.
// Ports:
//   req      in  NREQ  active requests
//   rr_last  in  1     index of the requester granted last in arbitration
//   yield_en in  1     force the tie to go to yield_to
//   yield_to in  1     requester that must win a tie when yield_en is set
//   gnt      out NREQ  one-hot winner, zero when req is zero
// -----------------------------------------------------------------------------
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            rr_last,
    input  logic            yield_en,
    input  logic            yield_to,
    output logic [NREQ-1:0] gnt
);

    logic tie_winner;

`ifdef RAM_ARB_RR_EN
    assign tie_winner = yield_en ? yield_to : ~rr_last;
`else
    // The pointer is meaningless under fixed priority.
    logic unused_rr_last;
    assign unused_rr_last = rr_last;
    assign tie_winner     = yield_en ? yield_to : 1'b0;
`endif

    always_comb begin
        // NOTE: default assignment first so no path leaves gnt unassigned,
        // which would infer a latch.
        gnt = '0;
        if (req[0] && req[1]) begin
            gnt[tie_winner] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Arbitrates one external 32K x 16 synchronous-write / combinational-read RAM
// between a CPU (requester 0) and a DMA/loader (requester 1). One access per
// cycle, read latency 1, optional burst lock bounded by MAX_LOCK grants.
// Configuration macro: RAM_ARB_RR_EN (round-robin instead of fixed priority).
// Parameters:
//   MAX_LOCK   max consecutive grants to a locked owner (1..255)
// Ports:
//   clk_i       in   1   clock, all state on rising edge
//   reset_i     in   1   synchronous active-high reset
//   req_i       in   2   request per requester
//   we_i        in   2   write enable per requester
//   lock_i      in   2   burst-lock request per requester
//   addr_i      in   30  {addr1, addr0}
//   wdata_i     in   32  {wdata1, wdata0}
//   gnt_o       out  2   one-hot accept strobe (combinational)
//   rvalid_o    out  2   read data valid, one cycle after a read grant
//   rdata_o     out  16  registered read data, shared
//   ram_load_o  out  1   RAM write strobe
//   ram_addr_o  out  15  RAM address
//   ram_data_o  out  16  RAM write data
//   ram_data_i  in   16  RAM read data (combinational)
// -----------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16
)
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        we_i,
    input  logic [NREQ-1:0]        lock_i,
    input  logic [NREQ*ADDR_W-1:0] addr_i,
    input  logic [NREQ*DATA_W-1:0] wdata_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [NREQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   ram_load_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic [DATA_W-1:0]      ram_data_o,
    input  logic [DATA_W-1:0]      ram_data_i
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    arb_state_t      state_q, state_d;
    logic            owner_q, owner_d;
    logic [7:0]      lock_cnt_q, lock_cnt_d;
    logic [7:0]      lock_cnt_inc;
    logic            rr_last_q, rr_last_d;
    logic            yield_q, yield_d;      // one-shot: other side wins the next tie
    logic [NREQ-1:0] rvalid_q;
    logic [NREQ-1:0] pick_gnt;
    logic [NREQ-1:0] rd_gnt;
    logic            owner_active;

    assign owner_active = req_i[owner_q] & lock_i[owner_q];
    assign lock_cnt_inc = lock_cnt_q + 8'd1;
    assign rd_gnt       = gnt_o & ~we_i;

    ram_arb_pick u_pick (
        .req      (req_i),
        .rr_last  (rr_last_q),
        .yield_en (yield_q),
        .yield_to (~owner_q),
        .gnt      (pick_gnt)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments for every register so all state
        // updates see pre-edge values regardless of statement order.
        if (reset_i) begin
            state_q    <= ST_ARB;
            owner_q    <= 1'b0;
            lock_cnt_q <= 8'd0;
            rr_last_q  <= 1'b1;         // requester 0 wins the first tie
            yield_q    <= 1'b0;
            rvalid_q   <= '0;
            rdata_o    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rr_last_q  <= rr_last_d;
            yield_q    <= yield_d;
            rvalid_q   <= rd_gnt;
            if (|rd_gnt) begin
                rdata_o <= ram_data_i;
            end
        end
    end

    // A read granted just before reset must not surface during the reset cycle.
    assign rvalid_o = rvalid_q & {NREQ{~reset_i}};

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rr_last_d  = rr_last_q;
        yield_d    = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (|pick_gnt) begin
                    rr_last_d = pick_gnt[1];
                    if (lock_i[pick_gnt[1]]) begin
                        owner_d = pick_gnt[1];
                        // The arbitration grant already counts as grant 1.
                        if (MAX_LOCK_C == 8'd1) begin
                            yield_d = 1'b1;
                        end else begin
                            state_d    = ST_LOCKED;
                            lock_cnt_d = 8'd1;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (owner_active) begin
                    if (lock_cnt_inc == MAX_LOCK_C) begin
                        state_d    = ST_ARB;
                        lock_cnt_d = 8'd0;
                        yield_d    = 1'b1;
                    end else begin
                        lock_cnt_d = lock_cnt_inc;
                    end
                end else begin
                    // Owner released: bubble this cycle, arbitrate next.
                    state_d    = ST_ARB;
                    lock_cnt_d = 8'd0;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        gnt_o = '0;
        if (!reset_i) begin
            if (state_q == ST_ARB) begin
                gnt_o = pick_gnt;
            end else if (owner_active) begin
                gnt_o[owner_q] = 1'b1;
            end
        end
        // AND-OR mux: all RAM outputs fall to zero when nothing is granted.
        ram_load_o = |(gnt_o & we_i);
        ram_addr_o = ({ADDR_W{gnt_o[0]}} & addr_i[ADDR_W-1:0])
                   | ({ADDR_W{gnt_o[1]}} & addr_i[2*ADDR_W-1:ADDR_W]);
        ram_data_o = ({DATA_W{gnt_o[0]}} & wdata_i[DATA_W-1:0])
                   | ({DATA_W{gnt_o[1]}} & wdata_i[2*DATA_W-1:DATA_W]);
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL take parameter MAX_LOCK, default 16, max consecutive grants to one locked requester (range 1..255).
REQ-002 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_i  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req_i  in  2  request per requester; bit0 = CPU, bit1 = DMA/loader.
REQ-005 SHALL have port we_i  in  2  write enable per requester.
REQ-006 SHALL have port lock_i  in  2  burst-lock request per requester.
REQ-007 SHALL have port addr_i  in  30  packed 2x15 addresses, [14:0] = requester 0.
REQ-008 SHALL have port wdata_i  in  32  packed 2x16 write data, [15:0] = requester 0.
REQ-009 SHALL have port gnt_o  out  2  one-hot accept strobe, combinational.
REQ-010 SHALL have port rvalid_o  out  2  read-data-valid strobe, registered.
REQ-011 SHALL have port rdata_o  out  16  registered read data shared by both requesters.
REQ-012 SHALL have ports ram_load_o out 1, ram_addr_o out 15, ram_data_o out 16: drive the 32K x 16 RAM.
REQ-013 SHALL have port ram_data_i  in  16  combinational RAM read data.

Function
REQ-014 SHALL accept at most one access per cycle; gnt_o is at most one-hot and is 0 when req_i = 0.
REQ-015 SHALL, in the grant cycle for requester n, drive ram_addr_o = addr[n], ram_data_o = wdata[n], ram_load_o = we[n]; the write commits on that edge.
REQ-016 SHALL drive ram_load_o = 0, ram_addr_o = 0, ram_data_o = 0 in cycles with no grant.
REQ-017 SHALL, for a granted read, capture ram_data_i into rdata_o and pulse rvalid_o[n] on the next cycle (latency 1); granted writes never pulse rvalid_o.
REQ-018 SHALL hold rdata_o unchanged when no read completes.
REQ-019 SHALL require requesters to hold req/we/addr/wdata stable until gnt; deasserting req before gnt cancels with no side effect.
REQ-020 SHALL implement FSM states ARB and LOCKED, with owner register and lock counter lock_cnt.
REQ-021 SHALL, in ARB, pick a winner per REQ-028; if winner has lock_i set, go to LOCKED with owner = winner, lock_cnt = 1.
REQ-022 SHALL, in LOCKED, grant only the owner while req_i[owner] and lock_i[owner] are set, incrementing lock_cnt per grant.
REQ-023 SHALL return to ARB when owner drops req or lock, or when lock_cnt reaches MAX_LOCK; after a MAX_LOCK expiry, if the other requester is requesting, it SHALL win the next cycle regardless of priority.
REQ-024 SHALL, in LOCKED with owner idle (req low), grant nothing that cycle and return to ARB.
REQ-025 SHALL allow a read and a following back-to-back access by either requester in consecutive cycles (full throughput, no bubbles).

Reset
REQ-026 SHALL on reset_i: state = ARB, lock_cnt = 0, rvalid_o = 0, rdata_o = 0, RR pointer favouring requester 0; gnt_o and ram_load_o forced 0 during the reset cycle.
REQ-027 SHALL abandon any lock and suppress any pending rvalid when reset_i asserts mid-operation.

Configuration
REQ-028 SHALL, with macro RAM_ARB_RR_EN defined, arbitrate round-robin (last-granted requester loses a tie, pointer updated on every ARB-state grant); without it, fixed priority, requester 0 always wins a tie.

Structure
REQ-029 SHALL place ADDR_W = 15, DATA_W = 16, NREQ = 2 and the FSM state encoding in package ram_arb_pkg.
REQ-030 SHALL isolate the winner selection (priority/RR, pointer input, one-hot output) in sub-module ram_arb_pick; the RAM itself is instantiated outside this block.

Verification
REQ-031 Bench SHALL check: req=01, we0=1, addr0=0x0010, wdata0=0xBEEF, then read 0x0010 -> gnt=01 both cycles, rvalid_o[0] one cycle later, rdata_o=0xBEEF.
REQ-032 Bench SHALL check: req=11 both reads for 4 cycles -> RR: gnt 01,10,01,10; without RAM_ARB_RR_EN: gnt 01 x4.
REQ-033 Bench SHALL check: MAX_LOCK=4, requester 1 locked with req=11 held -> gnt=10 for 4 cycles, then 01, then LOCKED can re-enter.
REQ-034 Bench SHALL check: reset_i asserted cycle after a read grant -> rvalid_o stays 0, rdata_o = 0, state ARB.
REQ-035 Bench SHALL check: requester 0 writes 0x1234 to 0x7FFF while requester 1 reads 0x7FFF next cycle -> rdata_o = 0x1234 with rvalid_o[1].
